// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_responder
// Description : Memory-side responder for the execute-stage load/store port.
//               Latches one request, drives a word-wide synchronous SRAM for
//               WAIT_STATES+1 cycles, returns zero-extended lane data on loads
//               and stalls the requester while a transaction is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_responder #(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 16,
    parameter int WAIT_STATES  = 1
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic                    load_memory,
    input  logic                    store_memory,
    input  logic [ADDRESS_BITS-1:0] load_store_address,
    input  logic [BITS-1:0]         memory_out,
    input  logic [1:0]              memory_wr_mask,
    output logic                    mem_stall,
    output logic [BITS-1:0]         load_data,
    output logic                    load_valid,
    output logic [ADDRESS_BITS-2:0] sram_addr,
    output logic [BITS-1:0]         sram_wdata,
    output logic [1:0]              sram_be,
    output logic                    sram_ce,
    output logic                    sram_we,
    input  logic [BITS-1:0]         sram_rdata
);

    localparam logic [2:0] C_WAIT_INIT = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                  state_q;
    logic [2:0]              wait_q;
    logic [BITS-1:0]         load_data_q;
    logic                    load_valid_q;
    logic [ADDRESS_BITS-2:0] sram_addr_q;
    logic [BITS-1:0]         sram_wdata_q;
    logic [1:0]              sram_be_q;
    logic                    sram_ce_q;
    logic                    sram_we_q;
    logic [BITS-1:0]         w_lane_data;

    // The SRAM is word addressed, so the byte-address LSB is not needed.
    logic w_unused_addr_lsb;
    assign w_unused_addr_lsb = load_store_address[0];

    // Lane select of the read word, zero-extending single-byte results.
    always_comb begin
        w_lane_data = '0;
        case (sram_be_q)
            2'b11:   w_lane_data = sram_rdata;
            2'b10:   w_lane_data = {{(BITS-8){1'b0}}, sram_rdata[15:8]};
            2'b01:   w_lane_data = {{(BITS-8){1'b0}}, sram_rdata[7:0]};
            default: w_lane_data = '0;
        endcase
    end

    // Transaction FSM; the SRAM control registers double as the latched
    // request (sram_we_q marks a store for the whole ACCESS phase).
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q      <= ST_IDLE;
            wait_q       <= 3'd0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_be_q    <= 2'b00;
            sram_ce_q    <= 1'b0;
            sram_we_q    <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_memory || store_memory) begin
                        state_q      <= ST_ACCESS;
                        wait_q       <= C_WAIT_INIT;
                        sram_ce_q    <= 1'b1;
                        // A simultaneous load is dropped: the store wins.
                        sram_we_q    <= store_memory;
                        sram_addr_q  <= load_store_address[ADDRESS_BITS-1:1];
                        sram_wdata_q <= memory_out;
                        sram_be_q    <= memory_wr_mask;
                    end
                end
                ST_ACCESS: begin
                    if (wait_q != 3'd0) begin
                        wait_q <= wait_q - 3'd1;
                    end else begin
                        sram_ce_q <= 1'b0;
                        sram_we_q <= 1'b0;
                        if (sram_we_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            load_data_q  <= w_lane_data;
                            load_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers; stall is decoded from state.
    assign mem_stall  = (state_q != ST_IDLE);
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_be    = sram_be_q;
    assign sram_ce    = sram_ce_q;
    assign sram_we    = sram_we_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mem_responder
// Description : Self-checking bench; four responders with wait states 0/1/3/7,
//               each with its own SRAM model, checked against a word-array
//               reference model and a directed vector table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_responder;

    logic        CLK = 1'b0;
    logic        RSTb = 1'b0;
    logic        mem_clr = 1'b1;

    logic        ld    [4];
    logic        st    [4];
    logic [15:0] adr   [4];
    logic [15:0] wd    [4];
    logic [1:0]  msk   [4];
    logic        stall [4];
    logic [15:0] ldat  [4];
    logic        lv    [4];
    logic [14:0] sa    [4];
    logic [15:0] wdat  [4];
    logic [1:0]  be    [4];
    logic        ce    [4];
    logic        we    [4];
    logic [15:0] rdat  [4];

    logic [15:0] sram    [4][256];
    logic [15:0] ref_mem [4][256];
    logic [15:0] last_ld [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            localparam int W = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 7;
            cpu_mem_responder #(
                .BITS(16), .ADDRESS_BITS(16), .WAIT_STATES(W)
            ) u_dut (
                .CLK(CLK), .RSTb(RSTb),
                .load_memory(ld[g]), .store_memory(st[g]),
                .load_store_address(adr[g]), .memory_out(wd[g]),
                .memory_wr_mask(msk[g]), .mem_stall(stall[g]),
                .load_data(ldat[g]), .load_valid(lv[g]),
                .sram_addr(sa[g]), .sram_wdata(wdat[g]), .sram_be(be[g]),
                .sram_ce(ce[g]), .sram_we(we[g]), .sram_rdata(rdat[g])
            );
        end
    endgenerate

    // SRAM models: byte-lane writes on the clock edge, combinational read.
    always @(posedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_clr) begin
                for (int j = 0; j < 256; j++) sram[k][j] <= 16'h0000;
            end else if (ce[k] && we[k]) begin
                if (be[k][1]) sram[k][sa[k][7:0]][15:8] <= wdat[k][15:8];
                if (be[k][0]) sram[k][sa[k][7:0]][7:0]  <= wdat[k][7:0];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) rdat[k] = sram[k][sa[k][7:0]];
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 1 : (k == 2) ? 3 : 7;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One transaction on instance k, starting in an idle cycle (cycle 0).
    task automatic run_txn(input int k, input bit ld_i, input bit st_i,
                           input logic [15:0] a, input logic [15:0] d,
                           input logic [1:0] m, output logic [15:0] got);
        int          w = ws_of(k);
        bit          is_load = ld_i && !st_i;
        logic [15:0] word;
        logic [15:0] exp = 16'h0000;
        got = 16'h0000;
        check("idle_before", stall[k], 0);
        ld[k] = ld_i; st[k] = st_i; adr[k] = a; wd[k] = d; msk[k] = m;
        word = ref_mem[k][a[8:1]];
        if (st_i) begin
            if (m[1]) word[15:8] = d[15:8];
            if (m[0]) word[7:0]  = d[7:0];
            ref_mem[k][a[8:1]] = word;
        end else if (ld_i) begin
            case (m)
                2'b11:   exp = word;
                2'b10:   exp = word >> 8;
                2'b01:   exp = word & 16'h00FF;
                default: exp = 16'h0000;
            endcase
        end
        tick();
        ld[k] = 1'b0; st[k] = 1'b0;
        adr[k] = 16'($urandom); wd[k] = 16'($urandom); msk[k] = 2'($urandom);
        check("c1_we", we[k], st_i);
        check("c1_addr", sa[k], a[15:1]);
        check("c1_be", be[k], m);
        if (st_i) check("c1_wdata", wdat[k], d);
        for (int c = 1; c <= w + 2; c++) begin
            if (c > 1) tick();
            check("stall", stall[k], (c <= w + 1) || is_load);
            check("ce", ce[k], c <= w + 1);
            check("valid", lv[k], is_load && (c == w + 2));
        end
        if (is_load) begin
            got = ldat[k];
            check("load_data", got, exp);
            last_ld[k] = exp;
            tick();
            check("stall_after_load", stall[k], 0);
            check("valid_one_cycle", lv[k], 0);
        end else begin
            check("load_data_hold", ldat[k], last_ld[k]);
            check("sram_word", sram[k][a[8:1]], ref_mem[k][a[8:1]]);
        end
    endtask

    typedef struct {
        int          k;
        bit          ld;
        bit          st;
        logic [15:0] a;
        logic [15:0] d;
        logic [1:0]  m;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic [15:0] got;
        int          k;
        for (int i = 0; i < 4; i++) begin
            ld[i] = 0; st[i] = 0; adr[i] = 0; wd[i] = 0; msk[i] = 0; last_ld[i] = 0;
            for (int j = 0; j < 256; j++) ref_mem[i][j] = 16'h0000;
        end

        vt[0]  = '{1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000};
        vt[1]  = '{1, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, 16'hBEEF};
        vt[2]  = '{0, 1'b0, 1'b1, 16'h0021, 16'hA55A, 2'b11, 16'h0000};
        vt[3]  = '{0, 1'b1, 1'b0, 16'h0021, 16'h0000, 2'b10, 16'h00A5};
        vt[4]  = '{0, 1'b1, 1'b0, 16'h0021, 16'h0000, 2'b01, 16'h005A};
        vt[5]  = '{0, 1'b0, 1'b1, 16'h0021, 16'h3C00, 2'b10, 16'h0000};
        vt[6]  = '{0, 1'b1, 1'b0, 16'h0021, 16'h0000, 2'b11, 16'h3C5A};
        vt[7]  = '{2, 1'b1, 1'b1, 16'h0040, 16'h1234, 2'b11, 16'h0000};
        vt[8]  = '{2, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b11, 16'h1234};
        vt[9]  = '{3, 1'b0, 1'b1, 16'h0042, 16'hABCD, 2'b11, 16'h0000};
        vt[10] = '{3, 1'b0, 1'b1, 16'h0042, 16'hFFFF, 2'b00, 16'h0000};
        vt[11] = '{3, 1'b1, 1'b0, 16'h0042, 16'h0000, 2'b11, 16'hABCD};

        // Reset and SRAM clear.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RSTb = 1'b1;
        mem_clr = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("rst_stall", stall[i], 0);
            check("rst_valid", lv[i], 0);
            check("rst_ce", ce[i], 0);
            check("rst_we", we[i], 0);
            check("rst_be", be[i], 0);
            check("rst_ldata", ldat[i], 0);
            check("rst_addr", sa[i], 0);
            check("rst_wdata", wdat[i], 0);
        end

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            run_txn(vt[i].k, vt[i].ld, vt[i].st, vt[i].a, vt[i].d, vt[i].m, got);
            if (vt[i].ld && !vt[i].st) check("vec_load", got, vt[i].exp);
        end

        // Load held across a W=3 store: accepted at end of cycle 5, valid in 10.
        run_txn(2, 1'b0, 1'b1, 16'h0050, 16'h0000, 2'b11, got);
        st[2] = 1'b1; adr[2] = 16'h0050; wd[2] = 16'hCAFE; msk[2] = 2'b11;
        ref_mem[2][8'h28] = 16'hCAFE;
        tick();
        st[2] = 1'b0; ld[2] = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            check("held_stall", stall[2], c != 5 && c != 11);
            check("held_valid", lv[2], c == 10);
            if (c == 10) check("held_data", ldat[2], 16'hCAFE);
            if (c == 6) ld[2] = 1'b0;
            if (c < 11) tick();
        end
        last_ld[2] = 16'hCAFE;

        // Asynchronous reset in cycle 1 of a W=1 store abandons the write.
        run_txn(1, 1'b0, 1'b1, 16'h0030, 16'h1111, 2'b11, got);
        st[1] = 1'b1; adr[1] = 16'h0030; wd[1] = 16'h2222; msk[1] = 2'b11;
        tick();
        st[1] = 1'b0;
        check("rst_mid_ce_pre", ce[1], 1);
        #2 RSTb = 1'b0;
        #1;
        check("rst_mid_ce", ce[1], 0);
        check("rst_mid_we", we[1], 0);
        check("rst_mid_stall", stall[1], 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTb = 1'b1;
        for (int i = 0; i < 4; i++) last_ld[i] = 16'h0000;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rst_mid_idle", stall[1], 0);
            check("rst_mid_novalid", lv[1], 0);
        end
        check("rst_mid_nowrite", sram[1][8'h18], 16'h1111);

        // Randomized transactions against the reference model.
        for (int n = 0; n < 60; n++) begin
            bit rl, rs;
            k = n % 4;
            rl = 1'($urandom); rs = 1'($urandom);
            if (!rl && !rs) rl = 1'b1;
            run_txn(k, rl, rs, 16'($urandom_range(0, 511)), 16'($urandom),
                    2'($urandom), got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
